// File: rtl/instruction_loader_if.sv
// Byte-stream and BRAM write-port bundle for the instruction loader.
// The master side feeds bytes and observes the BRAM port; the slave is the loader.
interface instruction_loader_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [31:0]           dina;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wea,
        input  addra,
        input  dina
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wea,
        output addra,
        output dina
    );
endinterface

// File: rtl/instruction_loader.sv
// Instruction BRAM writer: length byte, little-endian words, XOR checksum.
// Holds the CPU in reset while loading and flags length or checksum errors.
module instruction_loader #(
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_error,
    instruction_loader_if.slave  bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   word_idx;
    logic [CW-1:0]   word_cnt;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_buf;
    logic [7:0]      csum;
    logic            accept;
    logic            len_bad;
    logic            last_word;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign len_bad   = {1'b0, bus.byte_data} > DEPTH_W;
    assign last_word = (word_idx + CW'(1)) == word_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    next_state = len_bad ? DONE : DATA;
                end
            end
            DATA: begin
                if (accept && byte_cnt == 2'd3) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = last_word ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from next_state so they align with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.byte_ready <= 1'b0;
            bus.wea        <= 1'b0;
            bus.addra      <= '0;
            bus.dina       <= '0;
            cpu_hold       <= 1'b0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            bus.byte_ready <= (next_state == LEN) ||
                              (next_state == DATA) ||
                              (next_state == CSUM);
            cpu_hold       <= (next_state == LEN) ||
                              (next_state == DATA) ||
                              (next_state == WRITE) ||
                              (next_state == CSUM);
            load_done      <= (next_state == DONE);
            bus.wea        <= (next_state == WRITE);
            if (state == IDLE && start) begin
                load_error <= 1'b0;
            end
            if (state == LEN && accept && len_bad) begin
                load_error <= 1'b1;
            end
            if (state == CSUM && accept && bus.byte_data != csum) begin
                load_error <= 1'b1;
            end
            if (state == DATA && accept && byte_cnt == 2'd3) begin
                bus.addra <= word_idx[ADDR_WIDTH-1:0];
                bus.dina  <= {bus.byte_data, word_buf};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            csum     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        word_idx <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        word_cnt <= (bus.byte_data == 8'd0) ?
                                    CW'(DEPTH) : CW'(bus.byte_data);
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        csum     <= csum ^ bus.byte_data;
                        case (byte_cnt)
                            2'd0:    word_buf[7:0]   <= bus.byte_data;
                            2'd1:    word_buf[15:8]  <= bus.byte_data;
                            2'd2:    word_buf[23:16] <= bus.byte_data;
                            default: word_buf        <= word_buf;
                        endcase
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + CW'(1);
                end
                default: begin
                    word_idx <= word_idx;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader against a stream-level reference model.
// Expected BRAM writes, error flag and timing are derived from the byte stream rules.
module tb_instruction_loader;
    logic clk;
    logic rst_n;
    logic start;
    logic cpu_hold;
    logic load_done;
    logic load_error;

    instruction_loader_if #(.ADDR_WIDTH(7)) bus ();

    instruction_loader #(
        .DEPTH(128),
        .ADDR_WIDTH(7)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .start(start),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_error(load_error),
        .bus(bus)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         w;
    logic [31:0] mem [0:255];
    int          tests;
    int          fails;
    int          cyc;
    int          n_writes;
    int          done_count;
    int          done_cyc;
    bit          done_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.wea) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_wea", 32'(bus.addra), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("addra", 32'(bus.addra), 32'(w.addr));
                check("dina", bus.dina, w.data);
            end
        end
        if (load_done && !done_prev) begin
            done_cyc = cyc;
            done_count++;
        end
        done_prev = load_done;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = $urandom;
    endtask

    task automatic run_load(input logic [7:0] len, input logic [7:0] cxor,
                            input bit gaps, input bit stray, input bit timed);
        int         n;
        int         s;
        int         k;
        bit         bad;
        logic [7:0] cs;
        logic [31:0] word;
        n   = (len == 8'd0) ? 128 : int'(len);
        bad = int'(len) > 128;
        cs  = 8'h00;
        exp_q.delete();
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{addr: 7'(i), data: mem[i]});
                word = mem[i];
                cs = cs ^ word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
            end
        end
        n_writes = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("ready_after_start", 32'(bus.byte_ready), 32'd1);
        @(negedge clk);
        start = 1'b0;
        send_byte(len, gaps);
        if (bad) begin
            check("done_after_len", 32'(load_done), 32'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                word = mem[i];
                for (int j = 0; j < 4; j++) begin
                    send_byte(word[8*j +: 8], gaps);
                    if (stray && i == 0 && j == 1) pulse_start();
                end
            end
            send_byte(cs ^ cxor, gaps);
        end
        k = 0;
        while (!load_done && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_seen", 32'(load_done), 32'd1);
        check("load_error", 32'(load_error), 32'(bad || cxor != 8'h00));
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("n_writes", 32'(n_writes), bad ? 32'd0 : 32'(n));
        check("exp_left", 32'(exp_q.size()), 32'd0);
        if (timed) check("load_cycles", 32'(done_cyc - s), 32'(5 * n + 2));
        if (!bad) begin
            check("addra_hold", 32'(bus.addra), 32'(n - 1));
            check("dina_hold", bus.dina, mem[n-1]);
        end
        @(posedge clk);
        #1;
        check("done_pulse_1cyc", 32'(load_done), 32'd0);
    endtask

    initial begin
        int dc;
        int nr;
        tests = 0;
        fails = 0;
        cyc = 0;
        n_writes = 0;
        done_count = 0;
        done_prev = 1'b0;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        rst_n = 1'b0;
        #1;
        check("rst_wea", 32'(bus.wea), 32'd0);
        check("rst_addra", 32'(bus.addra), 32'd0);
        check("rst_dina", bus.dina, 32'd0);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_outs", {29'd0, cpu_hold, load_done, load_error}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mem[0] = 32'h1122_3344;
        mem[1] = 32'h5566_7788;
        mem[2] = 32'h99AA_BBCC;
        exp_q.delete();
        pulse_start();
        send_byte(8'd3, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        dc = done_count;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.byte_ready), 32'd0);
        check("midrst_wea_addr", {31'd0, bus.wea} | 32'(bus.addra), 32'd0);
        check("midrst_dina", bus.dina, 32'd0);
        check("midrst_outs", {29'd0, cpu_hold, load_done, load_error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 32'(done_count), 32'(dc));

        mem[0] = 32'h0000_0013;
        run_load(8'd1, 8'h00, 1'b0, 1'b0, 1'b1);

        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0007;
        mem[2] = 32'h0109_5020;
        run_load(8'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        run_load(8'd3, 8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("error_sticky", 32'(load_error), 32'd1);
        run_load(8'd3, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
        run_load(8'd0, 8'h00, 1'b0, 1'b0, 1'b1);

        run_load(8'd200, 8'h00, 1'b0, 1'b0, 1'b0);
        run_load(8'd129, 8'h00, 1'b1, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            nr = $urandom_range(1, 12);
            for (int i = 0; i < nr; i++) mem[i] = $urandom;
            run_load(8'(nr), (t % 3 == 2) ? 8'($urandom_range(1, 255)) : 8'h00,
                     1'b1, t[0], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
